// File: rtl/icb_pkg.sv
// Shared ICB bus widths and the master-ID type used by the 2:1 ICB arbiter.
package icb_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 64;
    localparam int ICB_MASK_W = 8;

    typedef logic mst_id_t;

    localparam mst_id_t M0 = 1'b0;
    localparam mst_id_t M1 = 1'b1;

    function automatic mst_id_t other_id(input mst_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/icb_arb_chk.sv
// Protocol checker: a slave response with nothing outstanding is illegal.
module icb_arb_chk #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rsp_valid,
    input logic [CNT_W-1:0] cnt
);

    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid && (cnt == {CNT_W{1'b0}})));

    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_W'(DEPTH));

endmodule

// File: rtl/icb_arb_id_fifo.sv
// In-order FIFO of granted master IDs; one entry per outstanding ICB command.
module icb_arb_id_fifo
    import icb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  mst_id_t        din,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output mst_id_t        head,
    output logic [PTR_W:0] cnt
);

    mst_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status flags and guarded handshakes
    always_comb begin
        full    = (cnt == (PTR_W+1)'(DEPTH));
        empty   = (cnt == {(PTR_W+1){1'b0}});
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        head    = mem[rd_ptr];
    end

    // Storage, pointers (wrap modulo DEPTH) and occupancy count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            cnt    <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= M0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/icb_arbiter_2to1.sv
// Two ICB masters share one ICB slave: command arbitration with a hold-until-accepted
// lock, and in-order response routing via a FIFO of granted master IDs.
module icb_arbiter_2to1
    import icb_pkg::*;
#(
    parameter int OUTS_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_icb_cmd_valid,
    output logic                  m0_icb_cmd_ready,
    input  logic [ICB_ADDR_W-1:0] m0_icb_cmd_addr,
    input  logic                  m0_icb_cmd_read,
    input  logic [ICB_DATA_W-1:0] m0_icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] m0_icb_cmd_wmask,
    output logic                  m0_icb_rsp_valid,
    input  logic                  m0_icb_rsp_ready,
    output logic [ICB_DATA_W-1:0] m0_icb_rsp_rdata,
    output logic                  m0_icb_rsp_err,
    input  logic                  m1_icb_cmd_valid,
    output logic                  m1_icb_cmd_ready,
    input  logic [ICB_ADDR_W-1:0] m1_icb_cmd_addr,
    input  logic                  m1_icb_cmd_read,
    input  logic [ICB_DATA_W-1:0] m1_icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] m1_icb_cmd_wmask,
    output logic                  m1_icb_rsp_valid,
    input  logic                  m1_icb_rsp_ready,
    output logic [ICB_DATA_W-1:0] m1_icb_rsp_rdata,
    output logic                  m1_icb_rsp_err,
    output logic                  s_icb_cmd_valid,
    input  logic                  s_icb_cmd_ready,
    output logic [ICB_ADDR_W-1:0] s_icb_cmd_addr,
    output logic                  s_icb_cmd_read,
    output logic [ICB_DATA_W-1:0] s_icb_cmd_wdata,
    output logic [ICB_MASK_W-1:0] s_icb_cmd_wmask,
    input  logic                  s_icb_rsp_valid,
    output logic                  s_icb_rsp_ready,
    input  logic [ICB_DATA_W-1:0] s_icb_rsp_rdata,
    input  logic                  s_icb_rsp_err
);

    localparam int CNT_W      = $clog2(OUTS_DEPTH) + 1;
    localparam bit FIXED_PRIO = (ARB_MODE == 32'sd1);

    logic             lock;
    mst_id_t          lock_id;
    mst_id_t          rr_ptr;
    mst_id_t          grant;
    mst_id_t          hid;
    logic             grant_valid;
    logic             cmd_ready_g;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] cnt;

    // Grant selection: a locked grant is held until its command is accepted
    always_comb begin
        grant = M0;
        if (lock) begin
            grant = lock_id;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant = FIXED_PRIO ? M0 : rr_ptr;
        end else if (m0_icb_cmd_valid) begin
            grant = M0;
        end else if (m1_icb_cmd_valid) begin
            grant = M1;
        end else begin
            grant = FIXED_PRIO ? M0 : rr_ptr;
        end
    end

    // Command channel mux; full is judged on the pre-pop count
    always_comb begin
        grant_valid      = (grant == M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
        s_icb_cmd_valid  = rst_n & grant_valid & ~fifo_full;
        cmd_ready_g      = rst_n & s_icb_cmd_ready & ~fifo_full;
        m0_icb_cmd_ready = cmd_ready_g & (grant == M0);
        m1_icb_cmd_ready = cmd_ready_g & (grant == M1);
        s_icb_cmd_addr   = (grant == M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        s_icb_cmd_read   = (grant == M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
        s_icb_cmd_wdata  = (grant == M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        s_icb_cmd_wmask  = (grant == M1) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
        accept           = s_icb_cmd_valid & s_icb_cmd_ready;
    end

    // Response routing; a stray response with nothing outstanding is sunk
    always_comb begin
        m0_icb_rsp_valid = rst_n & s_icb_rsp_valid & ~fifo_empty & (hid == M0);
        m1_icb_rsp_valid = rst_n & s_icb_rsp_valid & ~fifo_empty & (hid == M1);
        s_icb_rsp_ready  = rst_n & (fifo_empty | ((hid == M1) ? m1_icb_rsp_ready
                                                              : m0_icb_rsp_ready));
        m0_icb_rsp_rdata = s_icb_rsp_rdata;
        m1_icb_rsp_rdata = s_icb_rsp_rdata;
        m0_icb_rsp_err   = s_icb_rsp_err;
        m1_icb_rsp_err   = s_icb_rsp_err;
        pop              = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty;
    end

    // Lock and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_id <= M0;
            rr_ptr  <= M0;
        end else if (accept) begin
            lock   <= 1'b0;
            rr_ptr <= other_id(grant);
        end else if (grant_valid) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end else begin
            lock <= lock;
        end
    end

    icb_arb_id_fifo #(.DEPTH(OUTS_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (hid),
        .cnt   (cnt)
    );

    icb_arb_chk #(.CNT_W(CNT_W), .DEPTH(OUTS_DEPTH)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsp_valid (s_icb_rsp_valid),
        .cnt       (cnt)
    );

endmodule

// File: tb/tb_icb_arbiter_2to1.sv
// Bench for icb_arbiter_2to1: instance 0 round-robin, instance 1 fixed priority,
// both checked every cycle against a queue-based reference model.
module tb_icb_arbiter_2to1;

    logic        clk;
    logic        rst_n;
    logic        mcv  [2][2];
    logic        mcr  [2][2];
    logic [31:0] mca  [2][2];
    logic        mcrd [2][2];
    logic [63:0] mcw  [2][2];
    logic [7:0]  mcm  [2][2];
    logic        mrv  [2][2];
    logic        mrr  [2][2];
    logic [63:0] mrd  [2][2];
    logic        mre  [2][2];
    logic        scv  [2];
    logic        scr  [2];
    logic [31:0] sca  [2];
    logic        scrd [2];
    logic [63:0] scw  [2];
    logic [7:0]  scm  [2];
    logic        srv  [2];
    logic        srr  [2];
    logic [63:0] srd  [2];
    logic        sre  [2];

    int total;
    int bad;

    // reference model: outstanding-ID queue, last accepted master, held grant
    int qbuf [2][256];
    int qh [2];
    int qn [2];
    int last_acc [2];
    bit lk [2];
    int lkid [2];

    bit cmd_hs [2][2];
    bit rsp_hs [2];
    int acc_log [2][16];
    int acc_n [2];
    int del_id [2][16];
    int del_err [2][16];
    int del_n [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        icb_arbiter_2to1 #(.OUTS_DEPTH(4), .ARB_MODE(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_icb_cmd_valid(mcv[g][0]), .m0_icb_cmd_ready(mcr[g][0]),
            .m0_icb_cmd_addr(mca[g][0]), .m0_icb_cmd_read(mcrd[g][0]),
            .m0_icb_cmd_wdata(mcw[g][0]), .m0_icb_cmd_wmask(mcm[g][0]),
            .m0_icb_rsp_valid(mrv[g][0]), .m0_icb_rsp_ready(mrr[g][0]),
            .m0_icb_rsp_rdata(mrd[g][0]), .m0_icb_rsp_err(mre[g][0]),
            .m1_icb_cmd_valid(mcv[g][1]), .m1_icb_cmd_ready(mcr[g][1]),
            .m1_icb_cmd_addr(mca[g][1]), .m1_icb_cmd_read(mcrd[g][1]),
            .m1_icb_cmd_wdata(mcw[g][1]), .m1_icb_cmd_wmask(mcm[g][1]),
            .m1_icb_rsp_valid(mrv[g][1]), .m1_icb_rsp_ready(mrr[g][1]),
            .m1_icb_rsp_rdata(mrd[g][1]), .m1_icb_rsp_err(mre[g][1]),
            .s_icb_cmd_valid(scv[g]), .s_icb_cmd_ready(scr[g]),
            .s_icb_cmd_addr(sca[g]), .s_icb_cmd_read(scrd[g]),
            .s_icb_cmd_wdata(scw[g]), .s_icb_cmd_wmask(scm[g]),
            .s_icb_rsp_valid(srv[g]), .s_icb_rsp_ready(srr[g]),
            .s_icb_rsp_rdata(srd[g]), .s_icb_rsp_err(sre[g])
        );
    end

    task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, want, $time);
        end
    endtask

    // Per-cycle check against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  n;
            int  g;
            int  hid;
            bit  full;
            bit  gv;
            bit  e_scv;
            bit  e_srr;
            bit  e_mcr [2];
            bit  e_mrv [2];
            n    = qn[k];
            full = (n == 4);
            hid  = (n > 0) ? qbuf[k][qh[k]] : 0;
            // tie-break: fixed mode always M0, round-robin the master not accepted last
            if (lk[k]) g = lkid[k];
            else if (mcv[k][0] && mcv[k][1]) g = (k == 1) ? 0 : 1 - last_acc[k];
            else if (mcv[k][0]) g = 0;
            else if (mcv[k][1]) g = 1;
            else g = (k == 1) ? 0 : 1 - last_acc[k];
            gv    = mcv[k][g];
            e_scv = rst_n && gv && !full;
            e_srr = rst_n && (n == 0 || mrr[k][hid]);
            for (int m = 0; m < 2; m++) begin
                e_mcr[m] = rst_n && (m == g) && scr[k] && !full;
                e_mrv[m] = rst_n && (n > 0) && (m == hid) && srv[k];
                cmp("cmd_ready", k, mcr[k][m], e_mcr[m]);
                cmp("rsp_valid", k, mrv[k][m], e_mrv[m]);
                if (e_mrv[m]) begin
                    cmp("rsp_rdata", k, mrd[k][m], srd[k]);
                    cmp("rsp_err", k, mre[k][m], sre[k]);
                end
            end
            cmp("s_cmd_valid", k, scv[k], e_scv);
            cmp("s_rsp_ready", k, srr[k], e_srr);
            if (e_scv) begin
                cmp("s_cmd_addr", k, sca[k], mca[k][g]);
                cmp("s_cmd_read", k, scrd[k], mcrd[k][g]);
                cmp("s_cmd_wdata", k, scw[k], mcw[k][g]);
                cmp("s_cmd_wmask", k, scm[k], mcm[k][g]);
            end
            for (int m = 0; m < 2; m++) cmd_hs[k][m] = mcv[k][m] && mcr[k][m];
            rsp_hs[k] = srv[k] && srr[k];
            if (scv[k] && scr[k]) begin
                if (acc_n[k] < 16) acc_log[k][acc_n[k]] = cmd_hs[k][1] ? 1 : 0;
                acc_n[k]++;
            end
            if (rsp_hs[k] && (mrv[k][0] || mrv[k][1])) begin
                if (del_n[k] < 16) begin
                    del_id[k][del_n[k]]  = mrv[k][1] ? 1 : 0;
                    del_err[k][del_n[k]] = mrv[k][1] ? int'(mre[k][1]) : int'(mre[k][0]);
                end
                del_n[k]++;
            end
            if (!rst_n) begin
                qh[k] = 0; qn[k] = 0; last_acc[k] = 1; lk[k] = 1'b0; lkid[k] = 0;
            end else begin
                if (n > 0 && srv[k] && e_srr) begin
                    qh[k] = (qh[k] + 1) % 256;
                    qn[k]--;
                end
                if (e_scv && scr[k]) begin
                    qbuf[k][(qh[k] + qn[k]) % 256] = g;
                    qn[k]++;
                    last_acc[k] = g;
                    lk[k] = 1'b0;
                end else if (gv) begin
                    lk[k] = 1'b1;
                    lkid[k] = g;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int m, input logic v, input logic [31:0] a, input logic rd);
        for (int k = 0; k < 2; k++) begin
            mcv[k][m] = v; mca[k][m] = a; mcrd[k][m] = rd;
            mcw[k][m] = {a, ~a}; mcm[k][m] = a[7:0] ^ 8'h5A;
        end
    endtask

    task automatic set_rsp(input logic v, input logic [63:0] d, input logic e);
        for (int k = 0; k < 2; k++) begin
            srv[k] = v; srd[k] = d; sre[k] = e;
        end
    endtask

    task automatic idle();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_cmd(1, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            scr[k] = 1'b1; mrr[k][0] = 1'b1; mrr[k][1] = 1'b1;
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            acc_n[k] = 0; del_n[k] = 0;
        end
    endtask

    initial begin
        total = 0; bad = 0;
        for (int k = 0; k < 2; k++) begin
            qh[k] = 0; qn[k] = 0; last_acc[k] = 1; lk[k] = 1'b0; lkid[k] = 0;
            rsp_hs[k] = 1'b0; cmd_hs[k][0] = 1'b0; cmd_hs[k][1] = 1'b0;
        end
        clear_logs();
        idle();
        rst_n = 1'b0;
        set_cmd(0, 1'b1, 32'h10, 1'b1);
        set_cmd(1, 1'b1, 32'h20, 1'b1);
        tick(); tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("rst_s_cmd_valid", k, scv[k], 1'b0);
            cmp("rst_m0_cmd_ready", k, mcr[k][0], 1'b0);
            cmp("rst_s_rsp_ready", k, srr[k], 1'b0);
        end
        idle();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) cmp("idle_s_rsp_ready", k, srr[k], 1'b1);
        tick();

        // single read from M0
        set_cmd(0, 1'b1, 32'h1000, 1'b1);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t1_m0_cmd_ready", k, mcr[k][0], 1'b1);
            cmp("t1_s_cmd_addr", k, sca[k], 32'h1000);
        end
        tick();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b1, 64'hDEAD_BEEF, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t1_m0_rsp_valid", k, mrv[k][0], 1'b1);
            cmp("t1_m0_rsp_rdata", k, mrd[k][0], 64'hDEAD_BEEF);
            cmp("t1_m1_rsp_valid", k, mrv[k][1], 1'b0);
        end
        tick();
        set_rsp(1'b0, 64'h0, 1'b0);

        // contention after reset: RR alternates, fixed priority keeps M0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_logs();
        set_cmd(0, 1'b1, 32'hA000, 1'b1);
        set_cmd(1, 1'b1, 32'hB000, 1'b0);
        repeat (4) tick();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_cmd(1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cmp("t2_accepts", k, acc_n[k], 4);
            for (int i = 0; i < 4; i++) cmp("t2_grant_seq", k, acc_log[k][i], (k == 0) ? (i % 2) : 0);
        end
        for (int i = 0; i < 4; i++) begin
            set_rsp(1'b1, {$urandom, $urandom}, 1'b0);
            tick();
        end
        set_rsp(1'b0, 64'h0, 1'b0);

        // lock: M1 stalled three cycles while M0 joins
        set_cmd(1, 1'b1, 32'h2000, 1'b0);
        for (int k = 0; k < 2; k++) scr[k] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) cmp("t3_s_cmd_valid", k, scv[k], 1'b1);
        tick();
        set_cmd(0, 1'b1, 32'h3000, 1'b1);
        repeat (2) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                cmp("t3_locked_addr", k, sca[k], 32'h2000);
                cmp("t3_m0_cmd_ready", k, mcr[k][0], 1'b0);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) scr[k] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t3_m1_accept", k, mcr[k][1], 1'b1);
            cmp("t3_m0_wait", k, mcr[k][0], 1'b0);
        end
        tick();
        set_cmd(1, 1'b0, 32'h0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t3_m0_after", k, mcr[k][0], 1'b1);
            cmp("t3_m0_addr", k, sca[k], 32'h3000);
        end
        tick();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_rsp(1'b1, 64'h1234, 1'b0);
        repeat (2) tick();
        set_rsp(1'b0, 64'h0, 1'b0);

        // full FIFO, then response plus new command
        for (int i = 0; i < 4; i++) begin
            set_cmd(i % 2, 1'b1, 32'h4000 + 32'(i * 8), 1'b0);
            set_cmd(1 - (i % 2), 1'b0, 32'h0, 1'b0);
            tick();
        end
        clear_logs();
        set_cmd(1, 1'b0, 32'h0, 1'b0);
        set_cmd(0, 1'b1, 32'h5000, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t4_full_ready", k, mcr[k][0], 1'b0);
            cmp("t4_full_s_valid", k, scv[k], 1'b0);
        end
        tick();
        set_rsp(1'b1, 64'h55, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t4_prepop_full", k, mcr[k][0], 1'b0);
            cmp("t4_head_m0", k, mrv[k][0], 1'b1);
        end
        tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t4_push_pop_ready", k, mcr[k][0], 1'b1);
            cmp("t4_head_m1", k, mrv[k][1], 1'b1);
        end
        tick();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        repeat (3) tick();
        set_rsp(1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cmp("t4_deliveries", k, del_n[k], 5);
            for (int i = 0; i < 5; i++) cmp("t4_order", k, del_id[k][i], i % 2);
        end

        // ordering with error and M1 back-pressure
        for (int i = 0; i < 4; i++) begin
            set_cmd(0, (i == 0 || i == 3) ? 1'b1 : 1'b0, 32'h6000 + 32'(i), 1'b1);
            set_cmd(1, (i == 1 || i == 2) ? 1'b1 : 1'b0, 32'h7000 + 32'(i), 1'b1);
            tick();
        end
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_cmd(1, 1'b0, 32'h0, 1'b0);
        clear_logs();
        set_rsp(1'b1, 64'hA1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) mrr[k][1] = 1'b0;
        set_rsp(1'b1, 64'hA2, 1'b0);
        repeat (2) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                cmp("t5_stall_ready", k, srr[k], 1'b0);
                cmp("t5_stall_valid", k, mrv[k][1], 1'b1);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) mrr[k][1] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) cmp("t5_release_ready", k, srr[k], 1'b1);
        tick();
        set_rsp(1'b1, 64'hA3, 1'b1);
        tick();
        set_rsp(1'b1, 64'hA4, 1'b0);
        tick();
        set_rsp(1'b0, 64'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cmp("t5_deliveries", k, del_n[k], 4);
            for (int i = 0; i < 4; i++) begin
                cmp("t5_order", k, del_id[k][i], (i == 1 || i == 2) ? 1 : 0);
                cmp("t5_err", k, del_err[k][i], (i == 2) ? 1 : 0);
            end
        end

        // reset with two outstanding and a held M1 grant
        set_cmd(0, 1'b1, 32'h8000, 1'b0);
        tick();
        set_cmd(0, 1'b0, 32'h0, 1'b0);
        set_cmd(1, 1'b1, 32'h8100, 1'b0);
        tick();
        set_cmd(1, 1'b1, 32'h8200, 1'b0);
        for (int k = 0; k < 2; k++) scr[k] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t6_rst_s_valid", k, scv[k], 1'b0);
            cmp("t6_rst_m1_ready", k, mcr[k][1], 1'b0);
            cmp("t6_rst_rsp_ready", k, srr[k], 1'b0);
        end
        tick();
        rst_n = 1'b1;
        set_cmd(0, 1'b1, 32'h9000, 1'b1);
        for (int k = 0; k < 2; k++) scr[k] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("t6_post_m0", k, mcr[k][0], 1'b1);
            cmp("t6_post_m1", k, mcr[k][1], 1'b0);
            cmp("t6_post_empty", k, srr[k], 1'b1);
        end
        tick();
        idle();
        set_rsp(1'b1, 64'h77, 1'b0);
        tick();
        set_rsp(1'b0, 64'h0, 1'b0);
        tick();

        // randomized traffic, independent per instance, masters hold valid until accepted
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom % 300) != 0;
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!mcv[k][m] || cmd_hs[k][m]) begin
                        mcv[k][m]  = ($urandom % 2) != 0;
                        mca[k][m]  = $urandom;
                        mcrd[k][m] = ($urandom % 2) != 0;
                        mcw[k][m]  = {$urandom, $urandom};
                        mcm[k][m]  = 8'($urandom);
                    end
                    mrr[k][m] = ($urandom % 4) != 0;
                end
                scr[k] = ($urandom % 4) != 0;
                if (!rst_n || qn[k] == 0) begin
                    srv[k] = 1'b0;
                end else if (!srv[k] || rsp_hs[k]) begin
                    srv[k] = ($urandom % 2) != 0;
                    srd[k] = {$urandom, $urandom};
                    sre[k] = ($urandom % 8) == 0;
                end
            end
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
